// File: rtl/evr_pkg.sv
// Shared definitions for the EVR event logger: code width, log entry layout
// and default FIFO depth.
package evr_pkg;

  localparam int EVR_CODE_WIDTH = 8;
  localparam int EVR_TS_WIDTH   = 64;
  localparam int EVR_FIFO_DEPTH = 16;

  // One logged event: the code, the timestamp seen with the strobe and
  // whether that timestamp was valid at the time.
  typedef struct packed {
    logic [EVR_CODE_WIDTH-1:0] code;
    logic [EVR_TS_WIDTH-1:0]   timestamp;
    logic                      ts_valid;
  } log_entry_t;

endpackage

// File: rtl/evr_log_fifo.sv
// Synchronous first-word fall-through FIFO. The head entry is always visible
// on data_o while the FIFO is non-empty; a push is accepted when the FIFO
// is not full or a pop happens in the same cycle. DEPTH must be a power of 2
// and at least 2 so the binary pointers wrap naturally.
module evr_log_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [WIDTH-1:0]               data_i,
  output logic [WIDTH-1:0]               data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  // Storage array: written at the tail on every accepted push.
  // NOTE: the storage is deliberately not reset; level_q alone decides which
  // slots hold live data, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Occupancy next state: +1 on push only, -1 on pop only, hold otherwise.
  always_comb begin
    // NOTE: the default first guarantees level_d is assigned on every path,
    // so no latch can be inferred.
    level_d = level_q;
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (!do_push && do_pop) level_d = level_q - LW'(1);
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Head entry straight from registered storage; forced to zero when empty
  // so the data outputs read 0 after reset.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/evr_event_logger.sv
// Time-stamped event logger on the EVR receive clock. Enabled event strobes
// are priority-encoded (lowest code wins), captured with the current
// timestamp into an FWFT FIFO and presented on a valid/ready stream.
// Build option: define EVR_EVENT_LOGGER_DROP_COUNT_EN to add the saturating
// dropCount port and counter; otherwise only the sticky overflow flag exists.
module evr_event_logger
  import evr_pkg::*;
#(
  parameter int EVSTROBE_COUNT  = 126,
  parameter int TIMESTAMP_WIDTH = EVR_TS_WIDTH,
  parameter int FIFO_DEPTH      = EVR_FIFO_DEPTH
) (
  input  logic                               evrRxClk,
  input  logic                               evrRxRstN,
  input  logic [EVSTROBE_COUNT:1]            evStrobe,
  input  logic [TIMESTAMP_WIDTH-1:0]         timestamp,
  input  logic                               timestampValid,
  input  logic [EVSTROBE_COUNT:1]            eventEnable,
  output logic                               logValid,
  input  logic                               logReady,
  output logic [EVR_CODE_WIDTH-1:0]          logCode,
  output logic [TIMESTAMP_WIDTH-1:0]         logTimestamp,
  output logic                               logTsValid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fillLevel,
  output logic                               overflow,
  input  logic                               clearOverflow
`ifdef EVR_EVENT_LOGGER_DROP_COUNT_EN
  ,
  output logic [15:0]                        dropCount
`endif
);

  logic [EVSTROBE_COUNT:1]   cand;
  logic                      any_cand;
  logic [EVR_CODE_WIDTH-1:0] win_code;
  logic [EVR_CODE_WIDTH-1:0] n_cand;
  logic [EVR_CODE_WIDTH-1:0] n_drop;
  logic                      drop;
  logic                      pop;
  logic                      accept;
  logic                      fifo_full;
  logic                      fifo_empty;
  log_entry_t                wr_entry;
  log_entry_t                head_entry;
  logic                      overflow_q;
  logic                      overflow_d;

  assign cand     = evStrobe & eventEnable;
  assign any_cand = |cand;
  assign n_cand   = EVR_CODE_WIDTH'($countones(cand));

  // Priority encoder: lowest-numbered enabled strobe wins.
  always_comb begin
    win_code = '0;
    for (int i = EVSTROBE_COUNT; i >= 1; i--) begin
      if (cand[i]) win_code = EVR_CODE_WIDTH'(i);
    end
  end

  // A full FIFO still takes the winner when the head leaves in the same cycle.
  assign logValid = !fifo_empty;
  assign pop      = logValid && logReady;
  assign accept   = any_cand && (!fifo_full || pop);
  assign n_drop   = n_cand - EVR_CODE_WIDTH'(accept);
  assign drop     = (n_drop != '0);

  assign wr_entry.code      = win_code;
  assign wr_entry.timestamp = timestamp;
  assign wr_entry.ts_valid  = timestampValid;

  evr_log_fifo #(
    .WIDTH ($bits(log_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (evrRxClk),
    .rst_n   (evrRxRstN),
    .push_i  (accept),
    .pop_i   (pop),
    .data_i  (wr_entry),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fillLevel)
  );

  assign logCode      = head_entry.code;
  assign logTimestamp = head_entry.timestamp;
  assign logTsValid   = head_entry.ts_valid;

  // Sticky overflow next state: a drop beats a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    if (drop)               overflow_d = 1'b1;
    else if (clearOverflow) overflow_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge evrRxClk) begin
    if (!evrRxRstN) overflow_q <= 1'b0;
    else            overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

`ifdef EVR_EVENT_LOGGER_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;
  logic [15:0] drop_cnt_d;
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt_q} + 17'(n_drop);

  // Drop counter next state: clear restarts from this cycle's drops,
  // otherwise accumulate and saturate at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clearOverflow)    drop_cnt_d = 16'(n_drop);
    else if (drop_sum[16]) drop_cnt_d = 16'hFFFF;
    else                   drop_cnt_d = drop_sum[15:0];
  end

  // Drop counter register.
  always_ff @(posedge evrRxClk) begin
    if (!evrRxRstN) drop_cnt_q <= '0;
    else            drop_cnt_q <= drop_cnt_d;
  end

  assign dropCount = drop_cnt_q;
`endif

endmodule

// File: tb/tb_evr_event_logger.sv
// Self-checking bench for evr_event_logger: directed scenarios plus random
// strobes/backpressure, all compared against a queue-based reference model.
module tb_evr_event_logger;

  localparam int N_EV  = 126;
  localparam int TSW   = 64;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_EV:1]     strobe;
  logic [TSW-1:0]    ts;
  logic              tv;
  logic [N_EV:1]     en;
  logic              log_valid;
  logic              ready;
  logic [7:0]        log_code;
  logic [TSW-1:0]    log_ts;
  logic              log_tv;
  logic [LW-1:0]     fill;
  logic              ovf;
  logic              clr;
`ifdef EVR_EVENT_LOGGER_DROP_COUNT_EN
  logic [15:0]       drop_count;
`endif

  always #5 clk = ~clk;

  evr_event_logger dut (
    .evrRxClk       (clk),
    .evrRxRstN      (rst_n),
    .evStrobe       (strobe),
    .timestamp      (ts),
    .timestampValid (tv),
    .eventEnable    (en),
    .logValid       (log_valid),
    .logReady       (ready),
    .logCode        (log_code),
    .logTimestamp   (log_ts),
    .logTsValid     (log_tv),
    .fillLevel      (fill),
    .overflow       (ovf),
    .clearOverflow  (clr)
`ifdef EVR_EVENT_LOGGER_DROP_COUNT_EN
    ,
    .dropCount      (drop_count)
`endif
  );

  typedef struct {
    logic [7:0]     code;
    logic [TSW-1:0] ts;
    logic           tv;
  } ent_t;

  ent_t mq[$];
  logic m_ovf;
  int   m_dc;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: applied once per rising edge using the inputs held there.
  task automatic model_edge();
    int   cands[$];
    bit   pop;
    bit   room;
    int   drops;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_dc  = 0;
      return;
    end
    for (int c = 1; c <= N_EV; c++)
      if (strobe[c] && en[c]) cands.push_back(c);
    pop  = (mq.size() > 0) && ready;
    room = (mq.size() < DEPTH) || pop;
    if (pop) e = mq.pop_front();
    drops = 0;
    if (cands.size() > 0) begin
      if (room) begin
        e.code = 8'(cands[0]);
        e.ts   = ts;
        e.tv   = tv;
        mq.push_back(e);
      end
      drops = cands.size() - (room ? 1 : 0);
    end
    if (drops > 0)  m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    if (clr)        m_dc = drops;
    else            m_dc = (m_dc + drops > 65535) ? 65535 : m_dc + drops;
  endtask

  task automatic compare_all();
    check("logValid", 64'(log_valid), 64'(mq.size() > 0));
    check("fillLevel", 64'(fill), 64'(mq.size()));
    check("overflow", 64'(ovf), 64'(m_ovf));
`ifdef EVR_EVENT_LOGGER_DROP_COUNT_EN
    check("dropCount", 64'(drop_count), 64'(m_dc));
`endif
    if (mq.size() > 0) begin
      check("logCode", 64'(log_code), 64'(mq[0].code));
      check("logTimestamp", log_ts, mq[0].ts);
      check("logTsValid", 64'(log_tv), 64'(mq[0].tv));
    end
  endtask

  // One clock: model follows the edge, DUT is sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic single_strobe(input int code);
    strobe       = '0;
    strobe[code] = 1'b1;
    ts           = {$urandom, $urandom};
    tv           = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst_n  = 1'b0;
    strobe = '0;
    en     = '0;
    ts     = '0;
    tv     = 1'b0;
    ready  = 1'b0;
    clr    = 1'b0;
    tick();
    tick();
    check("rst_code", 64'(log_code), 64'd0);
    check("rst_ts", log_ts, 64'd0);
    check("rst_fill", 64'(fill), 64'd0);
    rst_n = 1'b1;

    // Single event on code 0x7D.
    en[8'h7D]     = 1'b1;
    strobe[8'h7D] = 1'b1;
    ts            = 64'h0000_0005_0000_0010;
    tv            = 1'b1;
    tick();
    strobe = '0;
    check("single_valid", 64'(log_valid), 64'd1);
    check("single_code", 64'(log_code), 64'h7D);
    check("single_ts", log_ts, 64'h0000_0005_0000_0010);
    check("single_tv", 64'(log_tv), 64'd1);
    check("single_fill", 64'(fill), 64'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Priority between codes 3 and 9.
    en        = '0;
    en[3]     = 1'b1;
    en[9]     = 1'b1;
    strobe[3] = 1'b1;
    strobe[9] = 1'b1;
    ts        = {$urandom, $urandom};
    tick();
    strobe = '0;
    check("prio_code", 64'(log_code), 64'd3);
    check("prio_fill", 64'(fill), 64'd1);
    check("prio_ovf", 64'(ovf), 64'd1);
`ifdef EVR_EVENT_LOGGER_DROP_COUNT_EN
    check("prio_drops", 64'(drop_count), 64'd1);
`endif
    clr   = 1'b1;
    ready = 1'b1;
    tick();
    clr   = 1'b0;
    ready = 1'b0;
    check("clr_ovf", 64'(ovf), 64'd0);

    // Fill to capacity plus one with no consumer.
    en = '1;
    for (int i = 0; i < 17; i++) begin
      single_strobe($urandom_range(1, N_EV));
      tick();
    end
    strobe = '0;
    check("full_fill", 64'(fill), 64'd16);
    check("full_ovf", 64'(ovf), 64'd1);
`ifdef EVR_EVENT_LOGGER_DROP_COUNT_EN
    check("full_drops", 64'(drop_count), 64'd1);
`endif

    // Strobe into a full FIFO while the head is popped: no drop.
    single_strobe(8'h42);
    ready = 1'b1;
    tick();
    strobe = '0;
    ready  = 1'b0;
    check("fullpop_fill", 64'(fill), 64'd16);
`ifdef EVR_EVENT_LOGGER_DROP_COUNT_EN
    check("fullpop_drops", 64'(drop_count), 64'd1);
`endif
    ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("drained_fill", 64'(fill), 64'd0);
    ready = 1'b0;
    clr   = 1'b1;
    tick();
    clr = 1'b0;

    // Random strobes with random backpressure over many pointer wraps.
    en = '1;
    for (int i = 0; i < 10; i++) en[$urandom_range(1, N_EV)] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int r;
      r      = int'($urandom_range(0, 9));
      strobe = '0;
      if (r < 5) single_strobe($urandom_range(1, N_EV));
      if (r == 5) begin
        single_strobe($urandom_range(1, N_EV));
        strobe[$urandom_range(1, N_EV)] = 1'b1;
      end
      ready = 1'($urandom_range(0, 1));
      clr   = ($urandom_range(0, 49) == 0);
      tick();
    end
    strobe = '0;
    clr    = 1'b1;
    ready  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      clr = 1'b0;
    end
    check("pre_rst_empty", 64'(fill), 64'd0);

    // Reset mid-operation with fill=5, overflow=1 and a strobe present.
    en    = '1;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      single_strobe(i + 20);
      tick();
    end
    strobe     = '0;
    strobe[10] = 1'b1;
    strobe[30] = 1'b1;
    tick();
    strobe = '0;
    check("mid_fill", 64'(fill), 64'd5);
    check("mid_ovf", 64'(ovf), 64'd1);
    rst_n     = 1'b0;
    strobe[7] = 1'b1;
    tick();
    rst_n  = 1'b1;
    strobe = '0;
    check("rst_valid", 64'(log_valid), 64'd0);
    check("rst_fill2", 64'(fill), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    tick();
    check("post_rst_fill", 64'(fill), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/evr_event_logger.md
# evr_event_logger

Time-stamped event logger on the EVR receive clock domain, directly downstream of the small event receiver. It watches the per-event-code strobe bus, and for every enabled event code it captures the current 64-bit timestamp and its validity. Each capture is buffered in an on-chip FIFO and presented to a consumer over a valid/ready stream. Typical consumers are the interlock/mitigation logic and the software readout path.

## Interface
- `EVSTROBE_COUNT`, 126: width of the strobe bus; strobe bits are numbered 1..EVSTROBE_COUNT and equal the event code.
- `TIMESTAMP_WIDTH`, 64: timestamp width as {seconds, ticks}.
- `FIFO_DEPTH`, 16: number of entries; must be a power of 2 and at least 2.
- `evrRxClk` input 1: EVR recovered clock; the only clock.
- `evrRxRstN` input 1: synchronous, active-low reset.
- `evStrobe` input [EVSTROBE_COUNT:1]: single-cycle event strobes.
- `timestamp` input TIMESTAMP_WIDTH: current timestamp.
- `timestampValid` input 1: timestamp validity.
- `eventEnable` input [EVSTROBE_COUNT:1]: per-code log enable; static or quasi-static.
- `logValid` output 1: head entry available.
- `logReady` input 1: consumer accepts the head entry.
- `logCode` output 8: event code of the head entry.
- `logTimestamp` output TIMESTAMP_WIDTH: captured timestamp of the head entry.
- `logTsValid` output 1: `timestampValid` at capture time.
- `fillLevel` output $clog2(FIFO_DEPTH+1): number of entries held.
- `overflow` output 1: sticky flag, set when an event is dropped.
- `clearOverflow` input 1: clears `overflow` (and the drop counter, if compiled in).
- `dropCount` output 16: dropped-event counter; exists only with the macro defined (see Configuration).

## Operation
- **Candidate:** the bitwise AND of `evStrobe` and `eventEnable`. If more than one bit is set in a cycle, the lowest-numbered code wins and the rest are dropped; every dropped bit counts as a drop.
- **Capture:** an entry is {code, `timestamp`, `timestampValid`}, all sampled in the same cycle as the strobe. No realignment is applied.
- **Write:** the entry is written at the clock edge that samples the strobe, provided the FIFO is not full or a pop occurs in that same cycle.
- **Full with no pop:** the entry is discarded and `overflow` is set on that edge.
- **Pop:** happens when `logValid && logReady`. `logReady` is ignored while `logValid` is 0.
- **Output stability:** while `logValid` is high and `logReady` is low, the `log*` outputs hold stable.
- **FIFO pointers:** binary read and write pointers of width $clog2(FIFO_DEPTH). They wrap modulo FIFO_DEPTH.
- **Occupancy:** `fillLevel` ranges 0..FIFO_DEPTH. It goes up by 1 on a push without a pop, down by 1 on a pop without a push, and is unchanged on a simultaneous push and pop.
- **clearOverflow vs. new drop:** if `clearOverflow` and a new drop occur in the same cycle, the drop wins and `overflow` ends at 1.
- **Reset:** evrRxRstN=0 forces `fillLevel`=0, `logValid`=0, `overflow`=0 and `dropCount`=0 on the next edge. Pointers return to 0 and any held entries are lost. `log*` data outputs are don't-care while `logValid`=0 and reset to 0.
- **Reset during a strobe:** a strobe in a reset cycle is not logged.

## Timing
- **Write latency:** a strobe in cycle N produces `logValid`=1 in cycle N+1 when the FIFO was empty. There is no combinational strobe-to-output path.
- **Outputs:** `log*` outputs come from registered FIFO state (first-word fall-through). An entry popped in cycle M is replaced by the next entry in cycle M+1 at the earliest.
- **Sustained rate:** one push and one pop per cycle is sustained indefinitely at any occupancy of 1..FIFO_DEPTH.
- **Status outputs:** `fillLevel` and `overflow` are registered and reflect the state after the most recent edge.

## Configuration
- **Macro `EVR_EVENT_LOGGER_DROP_COUNT_EN`:**
  - **Defined:** the `dropCount` port and counter exist. The counter adds the number of dropped candidates each cycle, from both full-FIFO drops and same-cycle losers. It saturates at 16'hFFFF and is cleared by `clearOverflow`. If a clear and a drop occur in the same cycle, the result is the drop count of that cycle.
  - **Not defined:** no port and no counter; only the `overflow` flag is provided.

## Structure
- **Package `evr_pkg`:** holds
  - the event-code width constant (8);
  - the log entry typedef {code, timestamp, tsValid};
  - the default `FIFO_DEPTH`.
- **Sub-module `evr_log_fifo`:** a synchronous first-word fall-through FIFO with push/pop, full/empty and level, parameterised on entry width and depth.
- **Top level:** contains the priority encoder, the overflow/drop logic and the stream output.

## Test plan
- **Single event:** enable code 0x7D; strobe bit 0x7D at timestamp 0x0000_0005_0000_0010 with timestampValid=1. Expect the next cycle to show logValid=1, logCode=0x7D, logTimestamp=0x0000_0005_0000_0010, logTsValid=1 and fillLevel=1.
- **Priority:** enable codes 3 and 9; strobe both in one cycle. Expect one entry with logCode=3, overflow=1, and dropCount=1 (macro defined).
- **Fill to capacity:** FIFO_DEPTH=16 with logReady=0; send 17 enabled strobes. Expect fillLevel=16, overflow=1 and dropCount=1. The first 16 codes read back in order.
- **Full with simultaneous pop:** with the FIFO full, a strobe arrives in the same cycle as logReady=1. Expect no drop, fillLevel stays 16, and the new entry is last in read order.
- **Backpressure:** toggle logReady at random across more than 100 events spanning several pointer wraps. Expect in-order, lossless data; outputs hold stable while logReady=0.
- **Reset mid-operation:** with fillLevel=5 and overflow=1, drive evrRxRstN=0 for one cycle together with a strobe. Expect logValid=0, fillLevel=0 and overflow=0, with no entry logged.
